// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
//   Shared definitions for the UART command controller: FSM state encoding,
//   command opcodes, fixed operand register addresses and the error
//   response byte.
package uart_cmd_pkg;

   typedef enum logic [3:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      OP_A,
      OP_B,
      OP_FUN,
      ALU_WAIT,
      TX_LO,
      TX_HI
   } state_t;

   localparam logic [7:0] OPC_WR      = 8'hAA;
   localparam logic [7:0] OPC_RD      = 8'hBB;
   localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
   localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

   localparam int unsigned OPA_ADDR = 0;
   localparam int unsigned OPB_ADDR = 1;

   localparam logic [7:0] ERR_RESP_BYTE = 8'hEE;

   // States that wait for the next byte of a frame; these are the ones that
   // are timed and that abort on a receive error.
   function automatic logic is_byte_state(input state_t s);
      return (s inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, OP_FUN});
   endfunction

endpackage

// File: rtl/uart_cmd_tmo.sv
// uart_cmd_tmo
//   Inter-byte timeout. Down-counter loaded on every accepted byte; while
//   enabled it counts towards zero and flags expiry once zero is reached.
//   Ports:
//     CLK, RST   system clock, synchronous active-high reset
//     clr        accepted byte, reload the counter
//     en         frame in a timed state
//     expire     enabled and the terminal count has been reached
module uart_cmd_tmo #(
   parameter int TMO_CYCLES = 4096
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD = CW'(TMO_CYCLES - 1);

   logic [CW-1:0] cnt;

   // Loaded value is TMO_CYCLES-1, so zero is reached TMO_CYCLES-1 cycles
   // after the last accepted byte; the FSM acts on it at the following edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= LOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = en && (cnt == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
//   Command sequencer between UART_RX and the register file / ALU / UART_TX.
//   Frames: AA addr data (write), BB addr (read), CC A B fun (ALU with
//   operands), DD fun (ALU without operands). Results leave through a
//   valid/busy byte handshake.
//   Build option: define UART_CMD_ERR_RESP_EN to answer every dropped or
//   timed-out frame with an ERR_RESP_BYTE on TX.
//   Ports:
//     CLK, RST                 clock, synchronous active-high reset
//     RX_P_DATA/RX_D_VLD/RX_ERR received byte, strobe, parity|stop error
//     RF_RdData/RF_RdData_VLD  register-file read return
//     ALU_OUT/ALU_OUT_VLD      ALU result return
//     TX_BUSY                  transmitter busy
//     RF_WrEn/RF_RdEn/RF_Address/RF_WrData  register-file access
//     ALU_EN/ALU_FUN/CLK_GATE_EN            ALU launch and clock gate
//     TX_P_DATA/TX_D_VLD       byte to transmit, held until accepted
//     FRAME_ERR                one-cycle pulse on dropped/aborted frame
//
//   state    | meaning
//   IDLE     | waiting for an opcode byte
//   WR_ADDR  | write: waiting for address byte
//   WR_DATA  | write: waiting for data byte
//   RD_ADDR  | read: waiting for address byte
//   RD_WAIT  | read issued, waiting for RF_RdData_VLD
//   OP_A     | ALU: waiting for operand A
//   OP_B     | ALU: waiting for operand B
//   OP_FUN   | ALU: waiting for function byte
//   ALU_WAIT | ALU launched, waiting for ALU_OUT_VLD
//   TX_LO    | sending low (or only) result byte
//   TX_HI    | sending high ALU result byte
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int TMO_CYCLES = 4096
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
   input  logic                    RX_D_VLD,
   input  logic                    RX_ERR,
   input  logic [DATA_WIDTH-1:0]   RF_RdData,
   input  logic                    RF_RdData_VLD,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VLD,
   input  logic                    TX_BUSY,
   output logic                    RF_WrEn,
   output logic                    RF_RdEn,
   output logic [ADDR_WIDTH-1:0]   RF_Address,
   output logic [DATA_WIDTH-1:0]   RF_WrData,
   output logic                    ALU_EN,
   output logic [3:0]              ALU_FUN,
   output logic                    CLK_GATE_EN,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   output logic                    FRAME_ERR
);

   state_t state, state_nxt;

   logic                  rf_wren_nxt, rf_rden_nxt, alu_en_nxt, frame_err_nxt;
   logic                  clk_gate_nxt, tx_vld_nxt;
   logic [ADDR_WIDTH-1:0] rf_addr_nxt;
   logic [DATA_WIDTH-1:0] rf_wrdata_nxt, tx_data_nxt;
   logic [3:0]            alu_fun_nxt;
   logic [DATA_WIDTH-1:0] alu_hi, alu_hi_nxt;
   logic                  two_byte, two_byte_nxt;

   logic rx_ok, rx_bad, tmo_en, tmo_expire;

   assign rx_ok  = RX_D_VLD && !RX_ERR;
   assign rx_bad = RX_D_VLD &&  RX_ERR;
   assign tmo_en = is_byte_state(state);

   // Reloading on every good byte is harmless outside timed states: every
   // entry into a timed state is itself a good byte.
   uart_cmd_tmo #(
      .TMO_CYCLES (TMO_CYCLES)
   ) u_tmo (
      .CLK    (CLK),
      .RST    (RST),
      .clr    (rx_ok),
      .en     (tmo_en),
      .expire (tmo_expire)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         RF_WrEn     <= 1'b0;
         RF_RdEn     <= 1'b0;
         RF_Address  <= '0;
         RF_WrData   <= '0;
         ALU_EN      <= 1'b0;
         ALU_FUN     <= '0;
         CLK_GATE_EN <= 1'b0;
         TX_P_DATA   <= '0;
         TX_D_VLD    <= 1'b0;
         FRAME_ERR   <= 1'b0;
         alu_hi      <= '0;
         two_byte    <= 1'b0;
      end else begin
         state       <= state_nxt;
         RF_WrEn     <= rf_wren_nxt;
         RF_RdEn     <= rf_rden_nxt;
         RF_Address  <= rf_addr_nxt;
         RF_WrData   <= rf_wrdata_nxt;
         ALU_EN      <= alu_en_nxt;
         ALU_FUN     <= alu_fun_nxt;
         CLK_GATE_EN <= clk_gate_nxt;
         TX_P_DATA   <= tx_data_nxt;
         TX_D_VLD    <= tx_vld_nxt;
         FRAME_ERR   <= frame_err_nxt;
         alu_hi      <= alu_hi_nxt;
         two_byte    <= two_byte_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      rf_wren_nxt   = 1'b0;
      rf_rden_nxt   = 1'b0;
      alu_en_nxt    = 1'b0;
      frame_err_nxt = 1'b0;
      rf_addr_nxt   = RF_Address;
      rf_wrdata_nxt = RF_WrData;
      alu_fun_nxt   = ALU_FUN;
      clk_gate_nxt  = CLK_GATE_EN;
      tx_data_nxt   = TX_P_DATA;
      tx_vld_nxt    = TX_D_VLD;
      alu_hi_nxt    = alu_hi;
      two_byte_nxt  = two_byte;

      case (state)
         IDLE: begin
            if (rx_ok) begin
               if (RX_P_DATA == DATA_WIDTH'(OPC_WR)) begin
                  state_nxt = WR_ADDR;
               end else if (RX_P_DATA == DATA_WIDTH'(OPC_RD)) begin
                  state_nxt = RD_ADDR;
               end else if (RX_P_DATA == DATA_WIDTH'(OPC_ALU_OP)) begin
                  state_nxt    = OP_A;
                  clk_gate_nxt = 1'b1;
               end else if (RX_P_DATA == DATA_WIDTH'(OPC_ALU_NOP)) begin
                  state_nxt    = OP_FUN;
                  clk_gate_nxt = 1'b1;
               end
            end
         end
         WR_ADDR: begin
            if (rx_ok) begin
               rf_addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
               state_nxt   = WR_DATA;
            end
         end
         WR_DATA: begin
            if (rx_ok) begin
               rf_wrdata_nxt = RX_P_DATA;
               rf_wren_nxt   = 1'b1;
               state_nxt     = IDLE;
            end
         end
         RD_ADDR: begin
            if (rx_ok) begin
               rf_addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
               rf_rden_nxt = 1'b1;
               state_nxt   = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (RF_RdData_VLD) begin
               tx_data_nxt  = RF_RdData;
               two_byte_nxt = 1'b0;
               state_nxt    = TX_LO;
            end
         end
         OP_A: begin
            if (rx_ok) begin
               rf_addr_nxt   = ADDR_WIDTH'(OPA_ADDR);
               rf_wrdata_nxt = RX_P_DATA;
               rf_wren_nxt   = 1'b1;
               state_nxt     = OP_B;
            end
         end
         OP_B: begin
            if (rx_ok) begin
               rf_addr_nxt   = ADDR_WIDTH'(OPB_ADDR);
               rf_wrdata_nxt = RX_P_DATA;
               rf_wren_nxt   = 1'b1;
               state_nxt     = OP_FUN;
            end
         end
         OP_FUN: begin
            if (rx_ok) begin
               alu_fun_nxt = RX_P_DATA[3:0];
               alu_en_nxt  = 1'b1;
               state_nxt   = ALU_WAIT;
            end
         end
         ALU_WAIT: begin
            if (ALU_OUT_VLD) begin
               tx_data_nxt  = ALU_OUT[DATA_WIDTH-1:0];
               alu_hi_nxt   = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
               two_byte_nxt = 1'b1;
               clk_gate_nxt = 1'b0;
               state_nxt    = TX_LO;
            end
         end
         TX_LO, TX_HI: begin
            // Offer only into an idle transmitter; the busy rise while
            // offering is the acceptance, after which the offer is withdrawn.
            if (!TX_D_VLD) begin
               if (!TX_BUSY) begin
                  tx_vld_nxt = 1'b1;
               end
            end else if (TX_BUSY) begin
               tx_vld_nxt = 1'b0;
               if ((state == TX_LO) && two_byte) begin
                  tx_data_nxt = alu_hi;
                  state_nxt   = TX_HI;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A good byte takes priority over a timeout landing on the same cycle.
      if (is_byte_state(state) && !rx_ok && (rx_bad || tmo_expire)) begin
         frame_err_nxt = 1'b1;
         clk_gate_nxt  = 1'b0;
`ifdef UART_CMD_ERR_RESP_EN
         tx_data_nxt   = DATA_WIDTH'(ERR_RESP_BYTE);
         two_byte_nxt  = 1'b0;
         state_nxt     = TX_LO;
`else
         state_nxt     = IDLE;
`endif
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

   localparam int T = 64;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  RX_P_DATA = '0;
   logic        RX_D_VLD = 1'b0;
   logic        RX_ERR = 1'b0;
   logic [7:0]  RF_RdData = '0;
   logic        RF_RdData_VLD = 1'b0;
   logic [15:0] ALU_OUT = '0;
   logic        ALU_OUT_VLD = 1'b0;
   logic        TX_BUSY = 1'b0;
   logic        RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD, FRAME_ERR;
   logic [3:0]  RF_Address, ALU_FUN;
   logic [7:0]  RF_WrData, TX_P_DATA;

   uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TMO_CYCLES(T)) dut (
      .CLK(CLK), .RST(RST),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
      .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .TX_BUSY(TX_BUSY),
      .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
      .RF_WrData(RF_WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
      .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
      .FRAME_ERR(FRAME_ERR)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // environment: register file, ALU and transmitter models
   logic [7:0]  rf_mem  [16];
   logic [7:0]  exp_mem [16];
   logic [11:0] wr_log[$], exp_wr[$];
   logic [3:0]  rd_log[$], exp_rd[$];
   logic [3:0]  fun_log[$], exp_fun[$];
   logic [7:0]  tx_log[$], exp_tx[$];
   int ferr_cnt = 0, exp_ferr = 0;
   int proto_viol = 0, cg_viol = 0;
   int rd_dly_fix = 0;
   logic tx_hold = 1'b0;

   function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
      case (f)
         4'd0:    return 16'(a) + 16'(b);
         4'd1:    return 16'(a) - 16'(b);
         4'd2:    return 16'(a) * 16'(b);
         4'd3:    return {8'h00, a & b};
         default: return {a, b};
      endcase
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int rd_cnt, alu_cnt, busy_cnt, acc_dly;
      logic [3:0] rd_a;
      rd_cnt = 0; alu_cnt = 0; busy_cnt = 0; acc_dly = 0; rd_a = '0;
      forever begin
         tick();
         RF_RdData_VLD = 1'b0;
         ALU_OUT_VLD   = 1'b0;
         if (RF_WrEn) begin
            wr_log.push_back({RF_Address, RF_WrData});
            rf_mem[RF_Address] = RF_WrData;
         end
         if (RF_RdEn) begin
            rd_log.push_back(RF_Address);
            rd_a   = RF_Address;
            rd_cnt = (rd_dly_fix > 0) ? rd_dly_fix : int'($urandom_range(1, 3));
         end else if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               RF_RdData     = rf_mem[rd_a];
               RF_RdData_VLD = 1'b1;
            end
         end
         if (ALU_EN) begin
            fun_log.push_back(ALU_FUN);
            if (!CLK_GATE_EN) cg_viol++;
            ALU_OUT = alu_fn(rf_mem[0], rf_mem[1], ALU_FUN);
            alu_cnt = $urandom_range(1, 4);
         end else if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
               ALU_OUT_VLD = 1'b1;
               if (!CLK_GATE_EN) cg_viol++;
            end
         end
         if (FRAME_ERR) ferr_cnt++;
         // valid must never be seen while the transmitter was already busy
         if (TX_BUSY && TX_D_VLD) proto_viol++;
         if (TX_BUSY) begin
            if (busy_cnt > 0) busy_cnt--;
            else if (!tx_hold) TX_BUSY = 1'b0;
         end else if (tx_hold) begin
            TX_BUSY = 1'b1;
         end else if (TX_D_VLD) begin
            if (acc_dly > 0) acc_dly--;
            else begin
               tx_log.push_back(TX_P_DATA);
               TX_BUSY  = 1'b1;
               busy_cnt = $urandom_range(2, 6);
               acc_dly  = $urandom_range(0, 2);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic err, input int gap);
      RX_P_DATA = b;
      RX_ERR    = err;
      RX_D_VLD  = 1'b1;
      tick();
      RX_D_VLD  = 1'b0;
      RX_ERR    = 1'b0;
      repeat (gap) tick();
   endtask

   // Expected effects of a frame, from the command rules. err_idx: -1 none,
   // 0 error on opcode (byte ignored), k>0 error on k-th payload byte.
   task automatic run_frame(input logic [7:0] op, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int err_idx);
      logic [7:0] bytes [4];
      logic [15:0] res;
      int nb;
      bytes[0] = op; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
      nb = (op == 8'hAA) ? 2 : (op == 8'hBB) ? 1 : (op == 8'hCC) ? 3 : (op == 8'hDD) ? 1 : 0;
      for (int i = 0; i <= nb; i++) begin
         send_byte(bytes[i], i == err_idx, $urandom_range(0, 3));
         if (i == 0)
            check("cg_open", CLK_GATE_EN, (op == 8'hCC || op == 8'hDD) && err_idx != 0);
         if (i == err_idx) break;
      end
      if (err_idx != 0) begin
         if (op == 8'hAA && err_idx < 0) begin
            exp_wr.push_back({b1[3:0], b2});
            exp_mem[b1 % 16] = b2;
         end
         if (op == 8'hBB && err_idx < 0) begin
            exp_rd.push_back(b1[3:0]);
            exp_tx.push_back(exp_mem[b1 % 16]);
         end
         if (op == 8'hCC && (err_idx < 0 || err_idx > 1)) begin
            exp_wr.push_back({4'd0, b1}); exp_mem[0] = b1;
         end
         if (op == 8'hCC && (err_idx < 0 || err_idx > 2)) begin
            exp_wr.push_back({4'd1, b2}); exp_mem[1] = b2;
         end
         if ((op == 8'hCC || op == 8'hDD) && err_idx < 0) begin
            logic [3:0] f;
            f = (op == 8'hCC) ? b3[3:0] : b1[3:0];
            exp_fun.push_back(f);
            res = alu_fn(exp_mem[0], exp_mem[1], f);
            exp_tx.push_back(res[7:0]);
            exp_tx.push_back(res[15:8]);
         end
         if (err_idx > 0 && err_idx <= nb) begin
            exp_ferr = 1;
`ifdef UART_CMD_ERR_RESP_EN
            exp_tx.push_back(8'hEE);
`endif
         end
      end
   endtask

   task automatic check_frame(input string name);
      for (int c = 0; c < 400; c++) begin
         if (tx_log.size() >= exp_tx.size()) break;
         tick();
      end
      repeat (8) tick();
      check({name, ".n_wr"}, wr_log.size(), exp_wr.size());
      for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
         check($sformatf("%s.wr%0d", name, i), wr_log[i], exp_wr[i]);
      check({name, ".n_rd"}, rd_log.size(), exp_rd.size());
      for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
         check($sformatf("%s.rd%0d", name, i), rd_log[i], exp_rd[i]);
      check({name, ".n_alu"}, fun_log.size(), exp_fun.size());
      for (int i = 0; i < fun_log.size() && i < exp_fun.size(); i++)
         check($sformatf("%s.fun%0d", name, i), fun_log[i], exp_fun[i]);
      check({name, ".ferr"}, ferr_cnt, exp_ferr);
      check({name, ".n_tx"}, tx_log.size(), exp_tx.size());
      for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
         check($sformatf("%s.tx%0d", name, i), tx_log[i], exp_tx[i]);
      check({name, ".cg_end"}, CLK_GATE_EN, 0);
      check({name, ".proto"}, proto_viol + cg_viol, 0);
      wr_log.delete(); exp_wr.delete(); rd_log.delete(); exp_rd.delete();
      fun_log.delete(); exp_fun.delete(); tx_log.delete(); exp_tx.delete();
      ferr_cnt = 0; exp_ferr = 0; proto_viol = 0; cg_viol = 0;
   endtask

   function automatic logic [29:0] all_outs();
      return {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
              CLK_GATE_EN, TX_P_DATA, TX_D_VLD, FRAME_ERR};
   endfunction

   initial begin
      int k_seen, kind, err;
      logic [7:0] op;
      for (int i = 0; i < 16; i++) begin rf_mem[i] = '0; exp_mem[i] = '0; end

      RST = 1'b1;
      repeat (3) tick();
      check("reset_outs", all_outs(), 0);
      RST = 1'b0;
      tick();

      run_frame(8'hAA, 8'h05, 8'h3C, 8'h00, -1);
      check_frame("write");

      tx_hold = 1'b1;
      repeat (2) tick();
      run_frame(8'hBB, 8'h05, 8'h00, 8'h00, -1);
      repeat (10) tick();
      check("vld_while_busy", TX_D_VLD, 0);
      tx_hold = 1'b0;
      check_frame("read");

      run_frame(8'hCC, 8'h12, 8'h34, 8'h00, -1);
      check_frame("alu_cc");

      run_frame(8'hAA, 8'h05, 8'h77, 8'h00, 2);
      check_frame("err_data");
      run_frame(8'hAA, 8'h15, 8'h99, 8'h00, -1);
      check_frame("after_err");

      send_byte(8'hAA, 1'b0, 0);
      k_seen = -1;
      for (int k = 1; k <= T + 20; k++) begin
         tick();
         if (FRAME_ERR && k_seen < 0) k_seen = k;
      end
      check("tmo_cycle", k_seen, T);
      exp_ferr = 1;
`ifdef UART_CMD_ERR_RESP_EN
      exp_tx.push_back(8'hEE);
`endif
      check_frame("timeout");

      send_byte(8'hAA, 1'b0, T - 2);
      send_byte(8'h07, 1'b0, T - 2);
      send_byte(8'h5A, 1'b0, 0);
      exp_wr.push_back({4'd7, 8'h5A});
      exp_mem[7] = 8'h5A;
      check_frame("tmo_edge");

      rd_dly_fix = 30;
      run_frame(8'hBB, 8'h03, 8'h00, 8'h00, -1);
      send_byte(8'hAA, 1'b0, 0);
      send_byte(8'h03, 1'b0, 0);
      send_byte(8'h55, 1'b0, 0);
      send_byte(8'hDD, 1'b0, 0);
      rd_dly_fix = 0;
      check_frame("stray_rx");

      send_byte(8'hCC, 1'b0, 0);
      send_byte(8'h21, 1'b0, 0);
      exp_wr.push_back({4'd0, 8'h21});
      exp_mem[0] = 8'h21;
      check("cg_opb", CLK_GATE_EN, 1);
      RST = 1'b1;
      tick();
      check("rst_opb_outs", all_outs(), 0);
      RST = 1'b0;
      check_frame("rst_mid");
      run_frame(8'hDD, 8'h01, 8'h00, 8'h00, -1);
      check_frame("after_rst");

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0: op = 8'hAA;
            1: op = 8'hBB;
            2: op = 8'hCC;
            3: op = 8'hDD;
            default: begin
               op = 8'($urandom_range(0, 255));
               if (op inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) op = op ^ 8'h01;
            end
         endcase
         err = -1;
         if ($urandom_range(0, 3) == 0)
            err = (kind == 0) ? $urandom_range(0, 2) : (kind == 2) ? $urandom_range(0, 3) :
                  (kind == 4) ? 0 : $urandom_range(0, 1);
         run_frame(op, 8'($urandom), 8'($urandom), 8'($urandom), err);
         check_frame($sformatf("rnd%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
